avalon_burst_copy: RTL and testbench
====================================

AVALON_BURST_COPY -- requirements
Module: avalon_burst_copy

Interface
REQ-001 The block SHALL have parameter BURSTCOUNT_W, default 4, setting burstcount width; max burst MAXB = 2**(BURSTCOUNT_W-1) words.
REQ-002 The block SHALL have parameter LEN_W, default 16, setting the width of the transfer length.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high; both are carried on the Avalon interface as clk and reset.
REQ-004 The block SHALL have port avalon_h.clk, input, 1, clock.
REQ-005 The block SHALL have port avalon_h.reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port avalon_h (avalon_if.host), bundle, -, Avalon-MM host side.
REQ-007 The block SHALL have port avalon_h.address, output, 32, byte address, word aligned.
REQ-008 The block SHALL have ports avalon_h.read and avalon_h.write, output, 1 each, command strobes.
REQ-009 The block SHALL have port avalon_h.burstcount, output, BURSTCOUNT_W, words in burst.
REQ-010 The block SHALL have ports avalon_h.byteenable, output, 4, and avalon_h.writedata, output, 32.
REQ-011 The block SHALL have ports avalon_h.readdata, input, 32; avalon_h.readdatavalid, input, 1; avalon_h.waitrequest, input, 1.
REQ-012 The block SHALL have port start, input, 1, one-cycle request to copy.
REQ-013 The block SHALL have ports src_addr and dst_addr, input, 32 each, byte addresses, sampled on start.
REQ-014 The block SHALL have port len_words, input, LEN_W, word count, sampled on start.
REQ-015 The block SHALL have ports busy, output, 1, and done, output, 1-cycle completion pulse.

Function
REQ-016 The block SHALL implement states IDLE, RD_REQ, RD_DATA, WR_BURST, DONE.
REQ-017 IDLE: on start with len_words>0, the block SHALL latch src, dst, len and go to RD_REQ; with len_words==0 it SHALL go to DONE with no bus traffic.
REQ-018 start outside IDLE SHALL be ignored; busy SHALL be 1 in every state except IDLE.
REQ-019 Each burst length SHALL be B = min(remaining, MAXB).
REQ-020 RD_REQ: read=1, address=current src, burstcount=B, held stable until a cycle with waitrequest=0, then go to RD_DATA.
REQ-021 RD_DATA: each readdatavalid=1 cycle SHALL push readdata into the buffer; after B words, go to WR_BURST.
REQ-022 readdatavalid in any other state SHALL be ignored.
REQ-023 WR_BURST: write=1, address=current dst, burstcount=B, byteenable=4'b1111, writedata=buffer head, all constant for the whole burst.
REQ-024 In WR_BURST, a beat SHALL complete only on a cycle with waitrequest=0, which pops the buffer; writedata SHALL otherwise be held.
REQ-025 After B write beats, src and dst SHALL each advance by 4*B and remaining SHALL decrease by B; the block then goes to RD_REQ if remaining>0, else DONE.
REQ-026 read and write SHALL never be asserted in the same cycle.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Address arithmetic SHALL wrap modulo 2**32 with no error.
REQ-029 Words SHALL be delivered in order with no loss; buffer depth SHALL be MAXB and SHALL never overflow.

Reset
REQ-030 On reset, the block SHALL go to IDLE, with read=0, write=0, busy=0, done=0, burstcount=0, address=0, byteenable=0, and the buffer empty.
REQ-031 Reset asserted mid-burst SHALL abort the transfer immediately; no done pulse SHALL be produced.

Structure
REQ-032 Package avalon_copy_pkg SHALL hold the state enum copy_state_t and the MAXB helper function.
REQ-033 The buffer SHALL be a sub-module burst_fifo (synchronous, depth MAXB, width 32, push/pop/empty/full).

Verification
REQ-034 len=1, src=0x0, dst=0x100, zero-wait agent -> one read burstcount=1, one write burstcount=1 at 0x100, data matches, done pulses once.
REQ-035 len=8 -> single read burst of 8, single write burst of 8 at dst; 8 words match.
REQ-036 len=20, src=0x40, dst=0x400 -> read/write bursts of 8, 8, 4 at src/dst offsets 0x0, 0x20, 0x40.
REQ-037 Agent holds waitrequest=1 for 3 cycles on the command and on write beat 2 -> address, burstcount and writedata remain stable; no beat lost.
REQ-038 len=0 -> done one cycle after start; read and write remain 0.
REQ-039 Reset during RD_DATA of a len=16 copy -> all outputs return to reset values; done never pulses; a new start then completes normally.

Source files
------------

// File: rtl/avalon_copy_pkg.sv
// Shared types and helpers for the Avalon-MM burst copy engine.
// Holds the controller state encoding and the maximum-burst helper.
package avalon_copy_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } copy_state_t;

    // Largest burst expressible with a given burstcount width.
    function automatic int unsigned max_burst(input int unsigned burstcount_w);
        return 32'd1 << (burstcount_w - 1);
    endfunction

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bundle carrying clock, reset and the host/agent command signals.
// The host drives commands and write data; the agent returns read data and waitrequest.
interface avalon_if #(
    parameter int unsigned BURSTCOUNT_W = 4
) (
    input logic clk,
    input logic reset
);
    logic [31:0]             address;
    logic                    read;
    logic                    write;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic [3:0]              byteenable;
    logic [31:0]             writedata;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport host (
        input  clk,
        input  reset,
        input  readdata,
        input  readdatavalid,
        input  waitrequest,
        output address,
        output read,
        output write,
        output burstcount,
        output byteenable,
        output writedata
    );

    modport agent (
        input  clk,
        input  reset,
        input  address,
        input  read,
        input  write,
        input  burstcount,
        input  byteenable,
        input  writedata,
        output readdata,
        output readdatavalid,
        output waitrequest
    );

endinterface

// File: rtl/burst_fifo.sv
// Synchronous FIFO holding one read burst until it is written back out.
// Head word is visible combinationally; push when full and pop when empty are dropped.
module burst_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/avalon_burst_copy.sv
// Avalon-MM copy engine: reads a region in bursts of up to MAXB words, buffers each
// burst, and writes it back to the destination before fetching the next one.
module avalon_burst_copy
    import avalon_copy_pkg::*;
#(
    parameter int unsigned BURSTCOUNT_W = 4,
    parameter int unsigned LEN_W        = 16
) (
    avalon_if.host           avalon_h,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done
);
    localparam int unsigned MAXB = max_burst(BURSTCOUNT_W);

    copy_state_t             r_state;
    copy_state_t             w_state_nxt;
    logic [31:0]             r_src;
    logic [31:0]             w_src_nxt;
    logic [31:0]             r_dst;
    logic [31:0]             w_dst_nxt;
    logic [LEN_W-1:0]        r_rem;
    logic [LEN_W-1:0]        w_rem_nxt;
    logic [LEN_W-1:0]        w_rem_left;
    logic [BURSTCOUNT_W-1:0] r_burst;
    logic [BURSTCOUNT_W-1:0] w_burst_nxt;
    logic [BURSTCOUNT_W-1:0] r_beat;
    logic [BURSTCOUNT_W-1:0] w_beat_nxt;
    logic                    w_last_beat;
    logic                    w_push;
    logic                    w_pop;
    logic [31:0]             w_fifo_head;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;

    function automatic logic [BURSTCOUNT_W-1:0] f_burst_len(input logic [LEN_W-1:0] rem);
        if (rem >= LEN_W'(MAXB)) begin
            return BURSTCOUNT_W'(MAXB);
        end
        return BURSTCOUNT_W'(rem);
    endfunction

    burst_fifo #(
        .DEPTH (MAXB),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (avalon_h.clk),
        .i_rst   (avalon_h.reset),
        .i_push  (w_push),
        .i_data  (avalon_h.readdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge avalon_h.clk or posedge avalon_h.reset) begin
        if (avalon_h.reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_rem   <= w_rem_nxt;
            r_burst <= w_burst_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign w_last_beat = (r_beat == r_burst - 1'b1);
    assign w_rem_left  = r_rem - LEN_W'(r_burst);

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_rem_nxt   = r_rem;
        w_burst_nxt = r_burst;
        w_beat_nxt  = r_beat;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (len_words != '0) begin
                        w_src_nxt   = src_addr;
                        w_dst_nxt   = dst_addr;
                        w_rem_nxt   = len_words;
                        w_burst_nxt = f_burst_len(len_words);
                        w_beat_nxt  = '0;
                        w_state_nxt = RD_REQ;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            RD_REQ: begin
                if (!avalon_h.waitrequest) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (avalon_h.readdatavalid && !w_fifo_full) begin
                    w_push = 1'b1;
                    if (w_last_beat) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = WR_BURST;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (!avalon_h.waitrequest) begin
                    w_pop = 1'b1;
                    if (w_last_beat) begin
                        // Addresses wrap modulo 2**32 by plain truncation.
                        w_src_nxt   = r_src + (32'(r_burst) << 2);
                        w_dst_nxt   = r_dst + (32'(r_burst) << 2);
                        w_rem_nxt   = w_rem_left;
                        w_burst_nxt = f_burst_len(w_rem_left);
                        w_beat_nxt  = '0;
                        w_state_nxt = (w_rem_left != '0) ? RD_REQ : DONE;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus outputs decode from registered state only, so they hold steady under waitrequest.
    always_comb begin
        avalon_h.read       = 1'b0;
        avalon_h.write      = 1'b0;
        avalon_h.address    = '0;
        avalon_h.burstcount = '0;
        avalon_h.byteenable = '0;
        avalon_h.writedata  = '0;
        if (r_state == RD_REQ) begin
            avalon_h.read       = 1'b1;
            avalon_h.address    = r_src;
            avalon_h.burstcount = r_burst;
        end else if (r_state == WR_BURST) begin
            avalon_h.write      = 1'b1;
            avalon_h.address    = r_dst;
            avalon_h.burstcount = r_burst;
            avalon_h.byteenable = 4'b1111;
            avalon_h.writedata  = w_fifo_empty ? '0 : w_fifo_head;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_avalon_burst_copy.sv
// Self-checking bench for avalon_burst_copy: a memory-backed Avalon agent with optional
// random stalls, compared against a burst-splitting reference model.
module tb_avalon_burst_copy;
    localparam int unsigned BW   = 4;
    localparam int unsigned LW   = 16;
    localparam int          MAXB = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  bc;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [LW-1:0] len_words;
    logic          busy;
    logic          done;

    avalon_if #(.BURSTCOUNT_W(BW)) bus (.clk(clk), .reset(rst));

    avalon_burst_copy #(
        .BURSTCOUNT_W (BW),
        .LEN_W        (LW)
    ) dut (
        .avalon_h  (bus),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [logic [29:0]];
    logic [31:0] exp_q[$];
    cmd_t        exp_rd_q[$];
    cmd_t        exp_wr_q[$];
    cmd_t        rd_q[$];
    cmd_t        wr_q[$];

    int   obs_done_cnt;
    int   obs_first_done;
    int   obs_overlap;
    int   obs_stab;
    int   obs_be_err;
    int   obs_busy_err;
    int   obs_cmd_cycles;
    logic obs_busy_end;

    // Reference: seed source words, poison destination, and split the copy into bursts.
    task automatic prepare(input logic [31:0] s, input logic [31:0] d, input int len);
        logic [29:0] wi;
        int          rem;
        int          bl;
        logic [31:0] a;
        logic [31:0] b;
        cmd_t        c;
        exp_q.delete();
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int i = 0; i < len; i++) begin
            wi = s[31:2] + 30'(i);
            mem[wi] = $urandom;
            exp_q.push_back(mem[wi]);
        end
        for (int i = 0; i < len; i++) begin
            wi = d[31:2] + 30'(i);
            mem[wi] = ~exp_q[i];
        end
        rem = len;
        a   = s;
        b   = d;
        while (rem > 0) begin
            bl     = (rem < MAXB) ? rem : MAXB;
            c.bc   = 8'(bl);
            c.addr = a;
            exp_rd_q.push_back(c);
            c.addr = b;
            exp_wr_q.push_back(c);
            a   = a + 32'(4 * bl);
            b   = b + 32'(4 * bl);
            rem = rem - bl;
        end
    endtask

    function automatic int q_diff(input cmd_t a[$], input cmd_t b[$]);
        int n;
        int m;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) begin
            if (a[i] !== b[i]) n++;
        end
        return n;
    endfunction

    function automatic int data_diff(input logic [31:0] d);
        int          n;
        logic [29:0] wi;
        n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            wi = d[31:2] + 30'(i);
            if (!mem.exists(wi) || mem[wi] !== exp_q[i]) n++;
        end
        return n;
    endfunction

    // Issues one copy and plays the Avalon agent cycle by cycle on the falling edge.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                            input int scmd, input int sbeat, input bit rnd,
                            input int abort_at, input int ign_at);
        logic [31:0] rsp_q[$];
        cmd_t        c;
        cmd_t        cur_w;
        int          rd_stall;
        int          wr_stall;
        int          beat;
        int          budget;
        bit          logged;
        bit          wreq;
        bit          prev_wait;
        bit          prev_rd;
        bit          prev_wr;
        logic [31:0] prev_addr;
        logic [31:0] prev_wd;
        logic [BW-1:0] prev_bc;
        logic [29:0] wi;
        rd_q.delete();
        wr_q.delete();
        obs_done_cnt   = 0;
        obs_first_done = -1;
        obs_overlap    = 0;
        obs_stab       = 0;
        obs_be_err     = 0;
        obs_busy_err   = 0;
        obs_cmd_cycles = 0;
        rd_stall  = scmd;
        wr_stall  = (sbeat >= 0) ? 3 : 0;
        beat      = 0;
        logged    = 1'b0;
        prev_wait = 1'b0;
        prev_rd   = 1'b0;
        prev_wr   = 1'b0;
        prev_addr = '0;
        prev_wd   = '0;
        prev_bc   = '0;
        budget    = 60 + len * 20;
        @(negedge clk);
        start     = 1'b1;
        src_addr  = s;
        dst_addr  = d;
        len_words = LW'(len);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = (cyc == ign_at);
            if (start) begin
                src_addr  = $urandom;
                dst_addr  = $urandom;
                len_words = LW'(5);
            end
            if (cyc == abort_at) begin
                rst = 1'b1;
                #1;
                return;
            end
            if (done) begin
                obs_done_cnt++;
                if (obs_first_done < 0) obs_first_done = cyc;
            end else if (obs_first_done < 0 && !busy) begin
                obs_busy_err++;
            end
            if (bus.read || bus.write) obs_cmd_cycles++;
            if (bus.read && bus.write) obs_overlap++;
            if (prev_wait && prev_rd && (!bus.read || bus.address !== prev_addr ||
                                         bus.burstcount !== prev_bc)) obs_stab++;
            if (prev_wait && prev_wr && (!bus.write || bus.address !== prev_addr ||
                                         bus.burstcount !== prev_bc ||
                                         bus.writedata !== prev_wd)) obs_stab++;
            if (bus.write && rnd && $urandom_range(0, 3) == 0) begin
                bus.readdatavalid = 1'b1;
                bus.readdata      = $urandom;
            end else if (rsp_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.readdatavalid = 1'b1;
                bus.readdata      = rsp_q.pop_front();
            end else begin
                bus.readdatavalid = 1'b0;
                bus.readdata      = $urandom;
            end
            wreq = rnd && ($urandom_range(0, 2) == 0);
            if (bus.read) begin
                if (rd_stall > 0) begin
                    wreq = 1'b1;
                    rd_stall--;
                end else if (!wreq) begin
                    c.addr = bus.address;
                    c.bc   = 8'(bus.burstcount);
                    rd_q.push_back(c);
                    for (int i = 0; i < int'(bus.burstcount); i++) begin
                        wi = bus.address[31:2] + 30'(i);
                        rsp_q.push_back(mem.exists(wi) ? mem[wi] : 32'h0);
                    end
                    rd_stall = scmd;
                end
            end else if (bus.write) begin
                if (!logged) begin
                    cur_w.addr = bus.address;
                    cur_w.bc   = 8'(bus.burstcount);
                    wr_q.push_back(cur_w);
                    logged = 1'b1;
                end else if (bus.address !== cur_w.addr || 8'(bus.burstcount) !== cur_w.bc) begin
                    obs_stab++;
                end
                if (bus.byteenable !== 4'hF) obs_be_err++;
                if (beat == sbeat && wr_stall > 0) begin
                    wreq = 1'b1;
                    wr_stall--;
                end else if (!wreq) begin
                    wi = bus.address[31:2] + 30'(beat);
                    mem[wi] = bus.writedata;
                    beat++;
                    if (beat >= int'(bus.burstcount)) begin
                        beat     = 0;
                        logged   = 1'b0;
                        wr_stall = (sbeat >= 0) ? 3 : 0;
                    end
                end
            end
            bus.waitrequest = wreq;
            prev_wait = wreq;
            prev_rd   = bus.read;
            prev_wr   = bus.write;
            prev_addr = bus.address;
            prev_bc   = bus.burstcount;
            prev_wd   = bus.writedata;
            if (obs_first_done >= 0 && cyc >= obs_first_done + 2) break;
        end
        obs_busy_end      = busy;
        bus.readdatavalid = 1'b0;
        bus.waitrequest   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.read, bus.write, busy, done} !== 4'b0000)
            $display("FAIL reset_ctrl: rd/wr/busy/done=%b expected 0000",
                     {bus.read, bus.write, busy, done});
        else n_pass++;
        n_checks++;
        if ({bus.address, bus.burstcount, bus.byteenable} !== '0)
            $display("FAIL reset_bus: addr=%h bc=%0d be=%b expected all zero",
                     bus.address, bus.burstcount, bus.byteenable);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] t_src [5] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0040,
                                   32'hFFFF_FFF0, 32'h0000_5000};
        logic [31:0] t_dst [5] = '{32'h0000_0100, 32'h0000_2000, 32'h0000_0400,
                                   32'h0000_3000, 32'h0000_6000};
        int          t_len [5] = '{1, 8, 20, 12, 9};
        int          d;
        for (int k = 0; k < 5; k++) begin
            prepare(t_src[k], t_dst[k], t_len[k]);
            run_copy(t_src[k], t_dst[k], t_len[k], 0, -1, 1'b0, 0, (t_len[k] == 20) ? 3 : 0);
            d = q_diff(rd_q, exp_rd_q);
            n_checks++;
            if (d != 0) $display("FAIL dir%0d_rd_bursts: %0d mismatches, got %0d bursts want %0d",
                                 k, d, rd_q.size(), exp_rd_q.size());
            else n_pass++;
            d = q_diff(wr_q, exp_wr_q);
            n_checks++;
            if (d != 0) $display("FAIL dir%0d_wr_bursts: %0d mismatches, got %0d bursts want %0d",
                                 k, d, wr_q.size(), exp_wr_q.size());
            else n_pass++;
            d = data_diff(t_dst[k]);
            n_checks++;
            if (d != 0) $display("FAIL dir%0d_data: %0d wrong words, want 0", k, d);
            else n_pass++;
            n_checks++;
            if (obs_done_cnt != 1 || obs_busy_err != 0 || obs_busy_end !== 1'b0)
                $display("FAIL dir%0d_done_busy: done=%0d busy_err=%0d busy_end=%b want 1/0/0",
                         k, obs_done_cnt, obs_busy_err, obs_busy_end);
            else n_pass++;
            n_checks++;
            if (obs_overlap != 0 || obs_be_err != 0 || obs_stab != 0)
                $display("FAIL dir%0d_protocol: overlap=%0d be_err=%0d stab=%0d want 0/0/0",
                         k, obs_overlap, obs_be_err, obs_stab);
            else n_pass++;
        end
    endtask

    task automatic test_waitrequest();
        int d;
        prepare(32'h0000_0800, 32'h0000_0900, 12);
        run_copy(32'h0000_0800, 32'h0000_0900, 12, 3, 1, 1'b0, 0, 0);
        n_checks++;
        if (obs_stab != 0) $display("FAIL wait_stable: %0d unstable cycles, want 0", obs_stab);
        else n_pass++;
        d = q_diff(rd_q, exp_rd_q) + q_diff(wr_q, exp_wr_q);
        n_checks++;
        if (d != 0) $display("FAIL wait_bursts: %0d burst mismatches, want 0", d);
        else n_pass++;
        d = data_diff(32'h0000_0900);
        n_checks++;
        if (d != 0) $display("FAIL wait_data: %0d wrong words, want 0", d);
        else n_pass++;
        n_checks++;
        if (obs_done_cnt != 1) $display("FAIL wait_done: %0d pulses, want 1", obs_done_cnt);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        prepare(32'h0000_0010, 32'h0000_0020, 0);
        run_copy(32'h0000_0010, 32'h0000_0020, 0, 0, -1, 1'b0, 0, 0);
        n_checks++;
        if (obs_first_done != 1) $display("FAIL zero_done_time: done at cycle %0d, want 1",
                                          obs_first_done);
        else n_pass++;
        n_checks++;
        if (obs_done_cnt != 1) $display("FAIL zero_done_cnt: %0d pulses, want 1", obs_done_cnt);
        else n_pass++;
        n_checks++;
        if (obs_cmd_cycles != 0) $display("FAIL zero_no_bus: %0d command cycles, want 0",
                                          obs_cmd_cycles);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        int d;
        prepare(32'h0000_2000, 32'h0000_3000, 16);
        run_copy(32'h0000_2000, 32'h0000_3000, 16, 0, -1, 1'b0, 4, 0);
        bus.readdatavalid = 1'b0;
        bus.waitrequest   = 1'b0;
        n_checks++;
        if ({bus.read, bus.write, busy, done} !== 4'b0000)
            $display("FAIL abort_ctrl: rd/wr/busy/done=%b expected 0000",
                     {bus.read, bus.write, busy, done});
        else n_pass++;
        n_checks++;
        if ({bus.address, bus.burstcount, bus.byteenable} !== '0)
            $display("FAIL abort_bus: addr=%h bc=%0d be=%b expected all zero",
                     bus.address, bus.burstcount, bus.byteenable);
        else n_pass++;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_checks++;
        if (seen != 0 || wr_q.size() != 0)
            $display("FAIL abort_no_done: done pulses=%0d writes=%0d, want 0/0", seen, wr_q.size());
        else n_pass++;
        prepare(32'h0000_2400, 32'h0000_3400, 5);
        run_copy(32'h0000_2400, 32'h0000_3400, 5, 0, -1, 1'b0, 0, 0);
        d = data_diff(32'h0000_3400);
        n_checks++;
        if (d != 0) $display("FAIL abort_restart_data: %0d wrong words, want 0", d);
        else n_pass++;
        d = q_diff(rd_q, exp_rd_q) + q_diff(wr_q, exp_wr_q);
        n_checks++;
        if (d != 0 || obs_done_cnt != 1)
            $display("FAIL abort_restart_bursts: mismatches=%0d done=%0d, want 0/1",
                     d, obs_done_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        logic [31:0] d;
        int          len;
        int          e;
        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(1, 24);
            s   = {16'h0000, 16'($urandom_range(0, 16'hFF00)) & 16'hFFFC};
            d   = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
            prepare(s, d, len);
            run_copy(s, d, len, $urandom_range(0, 2), $urandom_range(0, 4) - 1, 1'b1, 0, 0);
            e = q_diff(rd_q, exp_rd_q) + q_diff(wr_q, exp_wr_q);
            n_checks++;
            if (e != 0) $display("FAIL rnd%0d_bursts: %0d mismatches (len %0d), want 0", k, e, len);
            else n_pass++;
            e = data_diff(d);
            n_checks++;
            if (e != 0) $display("FAIL rnd%0d_data: %0d wrong words (len %0d), want 0", k, e, len);
            else n_pass++;
            n_checks++;
            if (obs_done_cnt != 1 || obs_busy_err != 0 || obs_busy_end !== 1'b0)
                $display("FAIL rnd%0d_done_busy: done=%0d busy_err=%0d busy_end=%b want 1/0/0",
                         k, obs_done_cnt, obs_busy_err, obs_busy_end);
            else n_pass++;
            n_checks++;
            if (obs_overlap != 0 || obs_stab != 0 || obs_be_err != 0)
                $display("FAIL rnd%0d_protocol: overlap=%0d stab=%0d be_err=%0d want 0/0/0",
                         k, obs_overlap, obs_stab, obs_be_err);
            else n_pass++;
        end
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        src_addr          = '0;
        dst_addr          = '0;
        len_words         = '0;
        bus.readdata      = '0;
        bus.readdatavalid = 1'b0;
        bus.waitrequest   = 1'b0;
        test_reset();
        test_directed();
        test_waitrequest();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
